// File: rtl/enigma_rotor_stream.sv
// enigma_rotor_stream: stepping multi-rotor, self-reciprocal letter cipher on a valid/ready byte stream.
// Default stepping is an odometer; define ENIGMA_NOTCH_EN for historical notch turnover with double step.

module enigma_rotor_stream #(
  parameter int N_ROTORS = 3,
  parameter int POS_W    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [N_ROTORS*POS_W-1:0] load_pos,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_data,
  output logic [N_ROTORS*POS_W-1:0] pos
);

  typedef logic [25:0][4:0] wiring_t;

  if (N_ROTORS < 1 || N_ROTORS > 3 || POS_W != 5) begin : g_bad_cfg
    $error("enigma_rotor_stream: N_ROTORS must be 1..3 and POS_W must be 5");
  end

  // Entry i of a wiring string maps letter i to the letter at that position.
  function automatic wiring_t to_wiring(input logic [8*26-1:0] s);
    logic [8*26-1:0] t;
    wiring_t         w;
    t = s;
    w = '0;
    for (int i = 0; i < 26; i++) begin
      w = {5'(t[8*26-1 -: 8] - 8'h41), w[25:1]};
      t = t << 8;
    end
    return w;
  endfunction

  function automatic wiring_t invert(input wiring_t w);
    wiring_t inv;
    inv = '0;
    for (int i = 0; i < 26; i++) begin
      inv[w[5'(i)]] = 5'(i);
    end
    return inv;
  endfunction

  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
  endfunction

  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    return (a >= b) ? 5'(a - b) : 5'({1'b0, a} + 6'd26 - {1'b0, b});
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : 5'(p + 5'd1);
  endfunction

  // One rotor pass: shift into the rotor frame, wire, shift back out.
  function automatic logic [4:0] rotor_stage(input wiring_t w, input logic [4:0] x,
                                             input logic [4:0] p);
    return sub26(w[add26(x, p)], p);
  endfunction

  localparam logic [2:0][25:0][4:0] ROT_FWD = {
    to_wiring("EKMFLGDQVZNTOWYHXUSPAIBRCJ"),
    to_wiring("AJDKSIRUXBLHWTMCQGZNPYFVOE"),
    to_wiring("BDFHJLCPRTXVZNYEIWGAKMSUQO")
  };
  localparam logic [2:0][25:0][4:0] ROT_BWD = {
    invert(ROT_FWD[2]), invert(ROT_FWD[1]), invert(ROT_FWD[0])
  };
  localparam wiring_t REFLECTOR = to_wiring("YRUHQSLDPXNGOKMIEBFZCWVJAT");

`ifdef ENIGMA_NOTCH_EN
  localparam logic [4:0] NOTCH_0 = 5'd21;  // 'V'
  localparam logic [4:0] NOTCH_1 = 5'd4;   // 'E'
`endif

  logic [N_ROTORS-1:0][4:0] r_pos;
  logic                     r_out_valid;
  logic [7:0]               r_out_data;

  logic [2:0][4:0]          w_cur3;
  logic [2:0][4:0]          w_next3;
  logic [2:0]               w_step;
  logic [N_ROTORS-1:0][4:0] w_next_pos;
  logic                     w_is_letter;
  logic                     w_accept;
  logic [7:0]               w_cipher;

  // Unused rotor slots read as 'A' so the stepping and cipher logic can always assume three.
  for (genvar g = 0; g < 3; g++) begin : g_slot
    if (g < N_ROTORS) begin : g_live
      assign w_cur3[g] = r_pos[g];
    end else begin : g_absent
      assign w_cur3[g] = 5'd0;
    end
  end

  assign in_ready    = !load && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_is_letter = (in_data >= 8'h41) && (in_data <= 8'h5A);

  always_comb begin
`ifdef ENIGMA_NOTCH_EN
    w_step[0] = 1'b1;
    w_step[1] = (w_cur3[0] == NOTCH_0) || ((N_ROTORS >= 3) && (w_cur3[1] == NOTCH_1));
    w_step[2] = (w_cur3[1] == NOTCH_1);
`else
    w_step[0] = 1'b1;
    w_step[1] = (w_cur3[0] == 5'd25);
    w_step[2] = w_step[1] && (w_cur3[1] == 5'd25);
`endif
    for (int k = 0; k < 3; k++) begin
      w_next3[2'(k)] = w_step[2'(k)] ? inc26(w_cur3[2'(k)]) : w_cur3[2'(k)];
    end
  end

  assign w_next_pos = w_next3[N_ROTORS-1:0];

  // Encryption uses the already-stepped positions.
  always_comb begin
    logic [4:0] x;
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    x = 5'(in_data - 8'h41);
    for (int k = 0; k < 3; k++) begin
      if (k < N_ROTORS) x = rotor_stage(ROT_FWD[2'(k)], x, w_next3[2'(k)]);
    end
    x = REFLECTOR[x];
    for (int k = 2; k >= 0; k--) begin
      if (k < N_ROTORS) x = rotor_stage(ROT_BWD[2'(k)], x, w_next3[2'(k)]);
    end
    w_cipher = w_is_letter ? (8'(x) + 8'h41) : in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_pos       <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_cipher;
        if (w_is_letter) r_pos <= w_next_pos;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (load) r_pos <= load_pos;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign pos       = r_pos;

endmodule

// File: tb/tb_enigma_rotor_stream.sv
// Randomized self-checking bench for enigma_rotor_stream against a string/arithmetic Enigma model.
// Compile with ENIGMA_NOTCH_EN defined to exercise notch stepping instead of the odometer.

module tb_enigma_rotor_stream;

  localparam int N = 3;

  logic           clk;
  logic           rst_n;
  logic           load;
  logic [N*5-1:0] load_pos;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     in_data;
  logic           out_valid;
  logic           out_ready;
  logic [7:0]     out_data;
  logic [N*5-1:0] pos;

  enigma_rotor_stream #(.N_ROTORS(N), .POS_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_pos  (load_pos),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .pos       (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  string      rot [3] = '{"BDFHJLCPRTXVZNYEIWGAKMSUQO", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                          "EKMFLGDQVZNTOWYHXUSPAIBRCJ"};
  string      refl    = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  int         m_pos [N];
  logic [7:0] m_q [$];
  logic [7:0] log_q [$];
  int         acc_cyc [$];
  int         cyc = 0;

  function automatic int stage_fwd(input string w, input int x, input int p);
    return (int'(w.getc((x + p) % 26)) - 65 - p + 26) % 26;
  endfunction

  function automatic int stage_bwd(input string w, input int x, input int p);
    int t = (x + p) % 26;
    for (int j = 0; j < 26; j++)
      if (int'(w.getc(j)) - 65 == t) return (j - p + 26) % 26;
    return 0;
  endfunction

  task automatic model_step();
`ifdef ENIGMA_NOTCH_EN
    bit s1, s2;
    s1 = (m_pos[0] == 21) || (N >= 3 && m_pos[1] == 4);
    s2 = (N >= 3) && (m_pos[1] == 4);
    m_pos[0] = (m_pos[0] + 1) % 26;
    if (N > 1 && s1) m_pos[1] = (m_pos[1] + 1) % 26;
    if (N > 2 && s2) m_pos[2] = (m_pos[2] + 1) % 26;
`else
    longint v = 0, m = 1;
    for (int k = 0; k < N; k++) begin v += m_pos[k] * m; m *= 26; end
    v = (v + 1) % m;
    for (int k = 0; k < N; k++) begin m_pos[k] = int'(v % 26); v /= 26; end
`endif
  endtask

  task automatic model_cipher(input logic [7:0] c, output logic [7:0] r);
    int x;
    if (c >= 8'h41 && c <= 8'h5A) begin
      model_step();
      x = int'(c) - 65;
      for (int k = 0; k < N; k++) x = stage_fwd(rot[k], x, m_pos[k]);
      x = int'(refl.getc(x)) - 65;
      for (int k = N - 1; k >= 0; k--) x = stage_bwd(rot[k], x, m_pos[k]);
      r = 8'(x + 65);
    end else begin
      r = c;
    end
  endtask

  function automatic logic [N*5-1:0] model_pos();
    logic [N*5-1:0] r;
    for (int k = 0; k < N; k++) r[5*k +: 5] = 5'(m_pos[k]);
    return r;
  endfunction

  // Scoreboard: sample mid-cycle, predict handshakes from the model's own view.
  bit         mon_en = 0;
  bit         mon_rdy;
  logic [7:0] mon_res;

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      mon_rdy = !load && (m_q.size() == 0 || out_ready);
      check("in_ready", 32'(in_ready), 32'(mon_rdy));
      check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("out_data", 32'(out_data), 32'(m_q[0]));
      check("pos", 32'(pos), 32'(model_pos()));
      if (m_q.size() != 0 && out_ready) log_q.push_back(m_q.pop_front());
      if (in_valid && mon_rdy) begin
        model_cipher(in_data, mon_res);
        m_q.push_back(mon_res);
        acc_cyc.push_back(cyc);
      end
      if (load) for (int k = 0; k < N; k++) m_pos[k] = int'(load_pos[5*k +: 5]);
    end
  end

  // out_ready source: 0 = always ready, 1 = random, 2 = held low
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send(input logic [7:0] c, output int waits);
    bit got;
    in_valid = 1'b1;
    in_data  = c;
    waits    = 0;
    forever begin
      @(negedge clk);
      got = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (got) break;
      waits++;
      if (waits >= 200) begin
        check("send_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] c);
    int w;
    send(c, w);
  endtask

  task automatic drain();
    int w = 0;
    while (m_q.size() != 0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_timeout", 32'(m_q.size()), 32'd0);
  endtask

  task automatic do_load(input logic [N*5-1:0] v);
    load     = 1'b1;
    load_pos = v;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send1(s.getc(i));
  endtask

  task automatic check_log(input string tag, input string exp);
    check({tag, "_len"}, 32'(log_q.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len() && i < log_q.size(); i++)
      check(tag, 32'(log_q[i]), 32'(exp.getc(i)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d errors", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N*5-1:0] v;
    int             w;
    int             r;
    logic [7:0]     c;

    rst_n    = 1'b0;
    load     = 1'b0;
    load_pos = '0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) m_pos[k] = 0;

    #22;
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    mon_en = 1;

    // Known-answer stream at full throughput
    log_q.delete();
    acc_cyc.delete();
    send_str("AAAAA");
    drain();
    check_log("kat_enc", "BDZGO");
    check("kat_pos", 32'(pos), 32'd5);
    check("kat_rate", 32'(acc_cyc[acc_cyc.size()-1] - acc_cyc[0]), 32'd4);

    // Reciprocity
    do_load('0);
    log_q.delete();
    send_str("BDZGO");
    drain();
    check_log("kat_dec", "AAAAA");

    // Non-letters echo without stepping
    log_q.delete();
    send_str("H 7I");
    drain();
    check("echo_space", 32'(log_q[1]), 32'h20);
    check("echo_digit", 32'(log_q[2]), 32'h37);

    // Backpressure with a waiting input
    rdy_mode  = 2;
    out_ready = 1'b0;
    send1("K");
    in_valid = 1'b1;
    in_data  = "L";
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    rdy_mode  = 0;
    out_ready = 1'b1;
    send("L", w);
    check("bp_release_wait", 32'(w), 32'd0);
    drain();

    // Load wins over a simultaneous input
    for (int k = 0; k < N; k++) v[5*k +: 5] = 5'($urandom_range(0, 25));
    in_valid = 1'b1;
    in_data  = "Q";
    load     = 1'b1;
    load_pos = v;
    @(negedge clk);
    check("ld_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    load = 1'b0;
    check("ld_pos", 32'(pos), 32'(v));
    send("Q", w);
    check("ld_accept_wait", 32'(w), 32'd0);
    drain();

    // Rotor 0 wrapping 25->0
    do_load(15'd25);
    send1("A");
    drain();
`ifdef ENIGMA_NOTCH_EN
    check("wrap_pos", 32'(pos), 32'd0);
    do_load(15'd116);
    send1("A");
    check("notch_pos1", 32'(pos), 32'd117);
    send1("A");
    check("notch_pos2", 32'(pos), 32'd150);
    send1("A");
    check("notch_pos3", 32'(pos), 32'd1207);
    drain();
`else
    check("wrap_pos", 32'(pos), 32'd32);
`endif

    // Randomized traffic with random backpressure and occasional loads
    rdy_mode = 1;
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        for (int k = 0; k < N; k++) v[5*k +: 5] = 5'($urandom_range(0, 25));
        do_load(v);
      end else begin
        if (r < 85) c = 8'($urandom_range(65, 90));
        else        c = 8'($urandom_range(0, 255));
        send1(c);
      end
    end
    drain();

    // Reset with a pending output
    rdy_mode  = 2;
    out_ready = 1'b0;
    send1("Z");
    #2;
    mon_en = 0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_pos", 32'(pos), 32'd0);
    m_q.delete();
    for (int k = 0; k < N; k++) m_pos[k] = 0;
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en    = 1;
    rdy_mode  = 0;
    out_ready = 1'b1;
    log_q.delete();
    send1("A");
    drain();
    check_log("post_rst", "B");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/enigma_rotor_stream.md
Name: enigma_rotor_stream

Overview:
- Multi-rotor, self-reciprocal letter cipher with stepping rotors, carried as an 8-bit ASCII stream with a valid/ready handshake.
- Successor to the fixed four-box static substitution. The substitution now changes with every letter, the rotor count is parametrised, and the same key decrypts what it encrypted.
- Sits between the character source (UART/testbench) and the output sink.

Parameters:
- N_ROTORS, 3, number of rotors in the chain, legal range 1..3. Rotor 0 is the fast, entry-side rotor.
- POS_W, 5, bits per rotor position (0..25 = 'A'..'Z'). Fixed; any other value is illegal.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  pulse; copy load_pos into the rotor positions
- load_pos  in  N_ROTORS*5  start positions; rotor k uses bits [5k+4:5k]
- in_valid  in  1  input character valid
- in_ready  out  1  block can accept a character
- in_data  in  8  ASCII input character
- out_valid  out  1  output character valid
- out_ready  in  1  sink accepts the output character
- out_data  out  8  ASCII output character
- pos  out  N_ROTORS*5  current rotor positions

Behaviour:
- Reset (async assert, sync deassert): positions all 0 ('A'); out_valid=0; out_data=8'h00; in_ready=1 once reset is released.
- Handshake: in_ready = !load && (!out_valid || out_ready). A transfer is in_valid && in_ready. Result is registered with latency 1: out_valid rises on the cycle after the transfer. Full throughput is 1 char/cycle when out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out_data and pos stay stable and no input is accepted.
- Letter path (in_data 'A'..'Z'):
  - Step the rotors first, then encrypt using the stepped positions.
  - Wirings: rotor 0 = "BDFHJLCPRTXVZNYEIWGAKMSUQO", rotor 1 = "AJDKSIRUXBLHWTMCQGZNPYFVOE", rotor 2 = "EKMFLGDQVZNTOWYHXUSPAIBRCJ".
  - Reflector = "YRUHQSLDPXNGOKMIEBFZCWVJAT".
  - Rotor stage forward: y = W[(x+p) mod 26] - p mod 26. Backward: inverse wiring, same offsets.
  - Full path: rotors 0..N-1 forward, then the reflector, then rotors N-1..0 backward.
- Non-letter (any other byte): passes through unchanged; rotors do not step.
- Stepping (default): odometer. Rotor 0 increments every letter. Rotor k+1 increments when rotor k wraps 25->0 on the same step. The last rotor wraps silently.
- Load: load=1 forces in_ready=0 that cycle, so load always wins over a simultaneous input. pos equals load_pos on the next cycle. A pending output is unaffected.
- Reset mid-stream: the output is dropped (out_valid=0) and positions return to 0.

Optional Feature:
- ENIGMA_NOTCH_EN defined: historical turnover replaces the odometer.
  - Rotor 0 carries into rotor 1 when rotor 0 steps off 'V'.
  - Rotor 1 carries into rotor 2 when rotor 1 steps off 'E'.
  - Double step: if rotor 1 sits at 'E' before a step, rotors 1 and 2 both advance.
  - Wrap 25->0 no longer carries.
- Not defined: odometer stepping only.

Test Plan:
- N_ROTORS=3, reset, stream "AAAAA" with out_ready=1 -> "BDZGO". pos = 0,0,5 (rotor 2,1,0) after the stream; one char per cycle after the first.
- Load 0/0/0, stream "BDZGO" -> "AAAAA" (reciprocity).
- Send " " and "7" mid-stream -> echoed unchanged; pos unchanged.
- Hold out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, out_data stable, pos stable. Release -> next char accepted on the following cycle.
- Assert load together with in_valid -> char not accepted that cycle; pos equals load_pos next cycle; the char is accepted on the following cycle.
- Odometer: load rotor 0='Z'(25), rotor 1=0; send "A" -> pos rotor 0=0, rotor 1=1.
- ENIGMA_NOTCH_EN: load 'A','D','U'; send 3 letters -> pos ADV, AEW, BFX.
